act_buf_reader: RTL

Streaming read engine for port B of the activation buffer. It takes a strided read descriptor (base, count, stride) and issues single-cycle reads on the buffer's read port. Returned words pass through an internal credit-controlled FIFO and leave on a valid/ready stream with a last marker. It sits between the NPU control sequencer and the PE-array input, and sustains one word per cycle when the consumer does not stall.

---
 rtl/act_buf_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/act_buf_reader.sv
// Strided read engine for activation-buffer port B: issues single-cycle reads
// under a credit limit and streams the returned words out through a small FIFO.
module act_buf_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 14,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [LEN_WIDTH-1:0]  cfg_count_i,
    input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  b_en_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    input  logic [DATA_WIDTH-1:0] b_rdata_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic                  inflightLast_q, inflightLast_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifoData_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifoLast_q;
    logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]      fifoCount_q;

    logic push;
    logic pop;
    logic creditOk;
    logic issue;
    logic issueLast;

    // The returning word is pushed one cycle after its read; a same-cycle pop
    // is deliberately not credited so the FIFO can never be pushed while full.
    assign push      = inflight_q;
    assign pop       = m_valid_o & m_ready_i;
    assign creditOk  = (fifoCount_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
    assign issue     = (state_q == RUN) && (issued_q < count_q) && creditOk;
    assign issueLast = (issued_q == count_q - LEN_WIDTH'(1));

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign b_en_o    = issue;
    assign b_addr_o  = addr_q;
    assign m_valid_o = (fifoCount_q != '0);
    assign m_data_o  = fifoData_q[rdPtr_q];
    assign m_last_o  = fifoLast_q[rdPtr_q];

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        stride_d       = stride_q;
        addr_d         = addr_q;
        issued_d       = issued_q;
        inflight_d     = 1'b0;
        inflightLast_d = 1'b0;
        done_d         = 1'b0;

        // A read issued in the abort cycle is dropped by leaving inflight clear.
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_d  = cfg_count_i;
                        stride_d = cfg_stride_i;
                        addr_d   = cfg_base_i;
                        issued_d = '0;
                        if (cfg_count_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_d         = addr_q + stride_q;
                        issued_d       = issued_q + LEN_WIDTH'(1);
                        inflight_d     = 1'b1;
                        inflightLast_d = issueLast;
                        if (issueLast) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight_q && ((fifoCount_q == '0) ||
                                        ((fifoCount_q == CNT_W'(1)) && pop))) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            stride_q       <= '0;
            addr_q         <= '0;
            issued_q       <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            stride_q       <= stride_d;
            addr_q         <= addr_d;
            issued_q       <= issued_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
        end
    end

    // Output FIFO; the storage is reset so the stream reads as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoData_q[i] <= '0;
            end
            fifoLast_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else if (abort_i) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= b_rdata_i;
                fifoLast_q[wrPtr_q] <= inflightLast_q;
                wrPtr_q             <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fifoCount_q <= fifoCount_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifoCount_q <= fifoCount_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !abort_i && push) begin
            assert (fifoCount_q != CNT_W'(FIFO_DEPTH));
        end
    end

endmodule
